aes_key_expansion_seq: RTL



---
 rtl/aes_key_expansion_seq_pkg.sv | 19 +
 rtl/aes_key_expansion_seq_sub_word.sv | 23 ++
 rtl/aes_key_expansion_seq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/aes_key_expansion_seq_pkg.sv
// Shared types and helpers for the iterative AES key schedule.
package aes_pkg;

  localparam int         NB        = 4;      // words per round key
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic {IDLE, EXPAND} state_t;

  // GF(2^8) multiply by x; steps the round constant.
  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  // Bit offset of schedule word i inside the flat round-key bus.
  function automatic int word_offset(input int i);
    return (i / NB) * NB * 32 + (NB - 1 - (i % NB)) * 32;
  endfunction

endpackage

// File: rtl/aes_key_expansion_seq_sub_word.sv
// SubWord: four parallel AES S-box lookups on a 32-bit word.
module sub_word (
  input  logic [31:0] a,
  output logic [31:0] y
);

  // Entry 0 is written first, so it lands at index 255; lookups use ~byte.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign y[b*8 +: 8] = SBOX[~a[b*8 +: 8]];
  end

endmodule

// File: rtl/aes_key_expansion_seq.sv
// Iterative AES key expansion, one 32-bit schedule word per clock.
// Optional macro AES_KEYEXP_ZEROIZE_EN adds a synchronous zeroize input.
module aes_key_expansion_seq
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [32*Nk-1:0]        key,
`ifdef AES_KEYEXP_ZEROIZE_EN
  input  logic                    zeroize,
`endif
  output logic [128*(Nr+1)-1:0]   w,
  output logic                    busy,
  output logic                    ready,
  output logic                    done
);

  localparam int NW = NB * (Nr + 1);
  localparam int CW = $clog2(NW + 1);
  localparam int IW = $clog2(NW);
  localparam int KW = $clog2(Nk);

  state_t                state_q, state_d;
  logic [NW-1:0][31:0]   sched;
  logic [Nk-1:0][31:0]   win;        // win[0] = w[i-Nk], win[Nk-1] = w[i-1]
  logic [Nk-1:0][31:0]   key_words;  // key_words[Nk-1] = key word 0
  logic [CW-1:0]         cnt;
  logic [2:0]            phase;      // i % Nk, tracked incrementally
  logic [7:0]            rcon;
  logic [31:0]           sw_in, sw_out, temp, new_word;
  logic                  last;

  assign key_words = key;
  assign last      = (cnt == CW'(NW - 1));

  for (genvar i = 0; i < NW; i++) begin : g_map
    assign w[word_offset(i) +: 32] = sched[i];
  end

  sub_word u_sub_word (.a(sw_in), .y(sw_out));

  // Next schedule word from the sliding window; RotWord only at phase 0.
  always_comb begin
    sw_in = (phase == 3'd0) ? {win[Nk-1][23:0], win[Nk-1][31:24]} : win[Nk-1];
    temp  = win[Nk-1];
    if (phase == 3'd0)                  temp = sw_out ^ {rcon, 24'h0};
    else if (Nk == 8 && phase == 3'd4)  temp = sw_out;
    new_word = win[0] ^ temp;
  end

  // Next-state logic: start launches, the last word returns to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = EXPAND;
      EXPAND:  if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef AES_KEYEXP_ZEROIZE_EN
    if (zeroize) state_d = IDLE;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Schedule storage, window, counters and handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sched <= '0;
      win   <= '0;
      cnt   <= '0;
      phase <= '0;
      rcon  <= RCON_INIT;
      busy  <= 1'b0;
      ready <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
`ifdef AES_KEYEXP_ZEROIZE_EN
      if (zeroize) begin
        sched <= '0;
        win   <= '0;
        cnt   <= '0;
        phase <= '0;
        rcon  <= RCON_INIT;
        busy  <= 1'b0;
        ready <= 1'b0;
      end else
`endif
      if (state_q == IDLE) begin
        if (start) begin
          // Words above Nk-1 keep stale data until rewritten; ready guards them.
          for (int k = 0; k < Nk; k++) begin
            sched[IW'(k)] <= key_words[KW'(Nk - 1 - k)];
            win[KW'(k)]   <= key_words[KW'(Nk - 1 - k)];
          end
          cnt   <= CW'(Nk);
          phase <= '0;
          rcon  <= RCON_INIT;
          busy  <= 1'b1;
          ready <= 1'b0;
        end
      end else begin
        sched[cnt[IW-1:0]] <= new_word;
        win   <= {new_word, win[Nk-1:1]};
        cnt   <= cnt + 1'b1;
        phase <= (phase == 3'(Nk - 1)) ? 3'd0 : phase + 3'd1;
        if (phase == 3'd0) rcon <= xtime(rcon);
        if (last) begin
          done  <= 1'b1;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      end
    end
  end

endmodule
